ifetch_bridge: RTL

IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

---
 rtl/ifetch_bridge_pkg.sv | 21 ++
 rtl/ifetch_bridge.sv | 115 +++++++++++
 2 files changed

// File: rtl/ifetch_bridge_pkg.sv
// Instruction-fetch bridge shared types.
// Widths and FSM state encoding.
package ifetch_bridge_pkg;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } ifetch_state_t;

  function automatic logic misaligned(
    input logic [W_ADDR-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_bridge.sv
// PC-stage to SRAM-like bus fetch bridge.
// One outstanding fetch, flush-cancel, one-entry result buffer.
module ifetch_bridge
  import ifetch_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_req,
  input  logic [W_ADDR-1:0] pc_addr,
  input  logic              flush,
  input  logic              ds_ready,
  output logic              fetch_stall,
  output logic              inst_valid,
  output logic [W_ADDR-1:0] inst_pc,
  output logic [W_DATA-1:0] inst_data,
  output logic              inst_adel,
  output logic              bus_req,
  output logic [W_ADDR-1:0] bus_addr,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [W_DATA-1:0] bus_rdata
);

  ifetch_state_t     state_q, state_d;
  logic              cancel_q, cancel_d;
  logic [W_ADDR-1:0] bus_addr_q, bus_addr_d;
  logic [W_ADDR-1:0] inst_pc_q, inst_pc_d;
  logic [W_DATA-1:0] inst_data_q, inst_data_d;
  logic              inst_adel_q, inst_adel_d;

  logic st_idle, st_addr, st_data, st_hold;
  logic accept, cancel_now, data_done;

  assign st_idle = state_q == S_IDLE;
  assign st_addr = state_q == S_ADDR;
  assign st_data = state_q == S_DATA;
  assign st_hold = state_q == S_HOLD;

  assign accept = pc_req & ~flush
                & (st_idle | (st_hold & ds_ready));
  assign cancel_now = cancel_q | flush;
  assign data_done = bus_data_ok
                   & (st_data | (st_addr & bus_addr_ok));

  assign fetch_stall = pc_req
                     & (cancel_q | (~flush & ~accept));
  assign inst_valid  = st_hold;
  assign bus_req     = st_addr;
  assign bus_addr    = bus_addr_q;
  assign inst_pc     = inst_pc_q;
  assign inst_data   = inst_data_q;
  assign inst_adel   = inst_adel_q;

  // Next-state: bus handshake, cancel tracking, new fetch launch.
  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    bus_addr_d  = bus_addr_q;
    inst_pc_d   = inst_pc_q;
    inst_data_d = inst_data_q;
    inst_adel_d = inst_adel_q;
    unique case (1'b1)
      st_addr: begin
        cancel_d = cancel_now;
        if (bus_addr_ok) state_d = S_DATA;
      end
      st_data: cancel_d = cancel_now;
      st_hold: begin
        if (flush | ds_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    if (data_done) begin
      if (cancel_now) begin
        state_d  = S_IDLE;
        cancel_d = 1'b0;
      end else begin
        state_d     = S_HOLD;
        inst_data_d = bus_rdata;
      end
    end
    if (accept) begin
      inst_pc_d = pc_addr;
      if (misaligned(pc_addr)) begin
        state_d     = S_HOLD;
        inst_adel_d = 1'b1;
        inst_data_d = '0;
      end else begin
        state_d     = S_ADDR;
        bus_addr_d  = pc_addr;
        inst_adel_d = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cancel_q    <= 1'b0;
      bus_addr_q  <= '0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      inst_adel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cancel_q    <= cancel_d;
      bus_addr_q  <= bus_addr_d;
      inst_pc_q   <= inst_pc_d;
      inst_data_q <= inst_data_d;
      inst_adel_q <= inst_adel_d;
    end
  end

endmodule
